// File: rtl/csa_accum_ctrl_if.sv
// Handshake bundle for the carry-save accumulator controller.
// The master side supplies operands and consumes results; the slave side
// is the controller itself.
interface csa_accum_ctrl_if #(
   parameter int DATA_W = 6,
   parameter int ACC_W  = 12,
   parameter int CNT_W  = 8
) ();

   // operand stream
   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] in_data;
   logic              in_last;

   // result stream
   logic              out_valid;
   logic              out_ready;
   logic [ACC_W-1:0]  out_sum;
   logic              out_ovf;
   logic [CNT_W-1:0]  out_count;

   // status
   logic              busy;

   modport master (
      output in_valid,
      output in_data,
      output in_last,
      output out_ready,
      input  in_ready,
      input  out_valid,
      input  out_sum,
      input  out_ovf,
      input  out_count,
      input  busy
   );

   modport slave (
      input  in_valid,
      input  in_data,
      input  in_last,
      input  out_ready,
      output in_ready,
      output out_valid,
      output out_sum,
      output out_ovf,
      output out_count,
      output busy
   );

endinterface

// File: rtl/csa_accum_ctrl.sv
// Multi-operand accumulator controller.
// Each accepted operand is folded into a redundant sum/carry pair with one
// 3:2 carry-save step. After the last operand of a group the pair is
// resolved by repeated half-add steps (sum ^= carry, carry = and << 1)
// until the carry vector is empty, then the binary result is offered on
// the output handshake. Carries shifted out of the top bit set a sticky
// overflow flag, so the flag is exact for the true group sum.
module csa_accum_ctrl #(
   parameter int DATA_W = 6,
   parameter int ACC_W  = 12,
   parameter int CNT_W  = 8
) (
   input logic              clk,
   input logic              rst_n,
   csa_accum_ctrl_if.slave  bus
);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ACCUM   = 2'd1,
      ST_RESOLVE = 2'd2,
      ST_DONE    = 2'd3
   } state_t;

   // Bitwise majority: the carry vector of a full adder per bit.
   function automatic logic [ACC_W-1:0] maj3(
      input logic [ACC_W-1:0] a,
      input logic [ACC_W-1:0] b,
      input logic [ACC_W-1:0] c
   );
      maj3 = (a & b) | (a & c) | (b & c);
   endfunction

   // Redundant accumulator state
   state_t             state_r;
   logic [ACC_W-1:0]   s_r;
   logic [ACC_W-1:0]   c_r;      // already weight-aligned (bit 0 always 0)
   logic               ovf_r;
   logic [CNT_W-1:0]   cnt_r;

   // Registered interface outputs
   logic               in_ready_r;
   logic               out_valid_r;
   logic [ACC_W-1:0]   out_sum_r;
   logic               out_ovf_r;
   logic [CNT_W-1:0]   out_count_r;
   logic               busy_r;

   // Combinational helpers
   logic               in_ready_s;
   logic               accept_s;
   logic [ACC_W-1:0]   d_s;
   logic [ACC_W-1:0]   acc_sum_s;
   logic [ACC_W-1:0]   acc_maj_s;
   logic [ACC_W-1:0]   acc_carry_s;
   logic [ACC_W-1:0]   res_and_s;
   logic [ACC_W-1:0]   res_carry_s;
   logic [CNT_W-1:0]   cnt_next_s;

   // in_ready is forced low for as long as reset is held, and the
   // registered value restores it on the first cycle out of reset.
   assign in_ready_s = in_ready_r & rst_n;
   assign accept_s   = bus.in_valid & in_ready_s;

   // Carry-save step for an incoming operand and half-add step for resolve.
   always_comb begin
      d_s                  = {ACC_W{1'b0}};
      d_s[DATA_W-1:0]      = bus.in_data;
      acc_sum_s            = s_r ^ c_r ^ d_s;
      acc_maj_s            = maj3(s_r, c_r, d_s);
      acc_carry_s          = {acc_maj_s[ACC_W-2:0], 1'b0};
      res_and_s            = s_r & c_r;
      res_carry_s          = {res_and_s[ACC_W-2:0], 1'b0};
      if (cnt_r == {CNT_W{1'b1}}) begin
         cnt_next_s = cnt_r;
      end else begin
         cnt_next_s = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end
   end

   // Controller FSM: accumulate, resolve, hold result until consumed.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_r     <= ST_IDLE;
         s_r         <= {ACC_W{1'b0}};
         c_r         <= {ACC_W{1'b0}};
         ovf_r       <= 1'b0;
         cnt_r       <= {CNT_W{1'b0}};
         in_ready_r  <= 1'b1;
         out_valid_r <= 1'b0;
         out_sum_r   <= {ACC_W{1'b0}};
         out_ovf_r   <= 1'b0;
         out_count_r <= {CNT_W{1'b0}};
         busy_r      <= 1'b0;
      end else begin
         case (state_r)
            ST_IDLE, ST_ACCUM: begin
               if (accept_s) begin
                  s_r    <= acc_sum_s;
                  c_r    <= acc_carry_s;
                  ovf_r  <= ovf_r | acc_maj_s[ACC_W-1];
                  cnt_r  <= cnt_next_s;
                  busy_r <= 1'b1;
                  if (bus.in_last) begin
                     state_r    <= ST_RESOLVE;
                     in_ready_r <= 1'b0;
                  end else begin
                     state_r    <= ST_ACCUM;
                  end
               end
            end
            ST_RESOLVE: begin
               if (c_r != {ACC_W{1'b0}}) begin
                  s_r   <= s_r ^ c_r;
                  c_r   <= res_carry_s;
                  ovf_r <= ovf_r | res_and_s[ACC_W-1];
               end else begin
                  // carry vector empty: s_r now holds the binary sum
                  state_r     <= ST_DONE;
                  out_valid_r <= 1'b1;
                  out_sum_r   <= s_r;
                  out_ovf_r   <= ovf_r;
                  out_count_r <= cnt_r;
               end
            end
            ST_DONE: begin
               if (bus.out_ready) begin
                  state_r     <= ST_IDLE;
                  s_r         <= {ACC_W{1'b0}};
                  c_r         <= {ACC_W{1'b0}};
                  ovf_r       <= 1'b0;
                  cnt_r       <= {CNT_W{1'b0}};
                  in_ready_r  <= 1'b1;
                  out_valid_r <= 1'b0;
                  out_sum_r   <= {ACC_W{1'b0}};
                  out_ovf_r   <= 1'b0;
                  out_count_r <= {CNT_W{1'b0}};
                  busy_r      <= 1'b0;
               end
            end
            default: begin
               state_r     <= ST_IDLE;
               s_r         <= {ACC_W{1'b0}};
               c_r         <= {ACC_W{1'b0}};
               ovf_r       <= 1'b0;
               cnt_r       <= {CNT_W{1'b0}};
               in_ready_r  <= 1'b1;
               out_valid_r <= 1'b0;
               out_sum_r   <= {ACC_W{1'b0}};
               out_ovf_r   <= 1'b0;
               out_count_r <= {CNT_W{1'b0}};
               busy_r      <= 1'b0;
            end
         endcase
      end
   end

   assign bus.in_ready  = in_ready_s;
   assign bus.out_valid = out_valid_r;
   assign bus.out_sum   = out_sum_r;
   assign bus.out_ovf   = out_ovf_r;
   assign bus.out_count = out_count_r;
   assign bus.busy      = busy_r;

endmodule

// File: tb/tb_csa_accum_ctrl.sv
// Directed bench for csa_accum_ctrl: a 12-bit accumulator instance for most
// groups and a 6-bit instance for the overflow case.
module tb_csa_accum_ctrl;

   logic clk;
   logic rst_n;
   int   checks = 0;
   int   errors = 0;
   int   cyc    = 0;
   int   last_acc;
   int   n;

   csa_accum_ctrl_if #(.DATA_W(6), .ACC_W(12), .CNT_W(8)) bus_a ();
   csa_accum_ctrl_if #(.DATA_W(6), .ACC_W(6),  .CNT_W(8)) bus_b ();

   csa_accum_ctrl #(.DATA_W(6), .ACC_W(12), .CNT_W(8)) dut_a (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus_a)
   );

   csa_accum_ctrl #(.DATA_W(6), .ACC_W(6), .CNT_W(8)) dut_b (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // edge counter used to measure result latency
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_a(input logic [5:0] d, input logic last);
      bus_a.in_valid = 1'b1;
      bus_a.in_data  = d;
      bus_a.in_last  = last;
      chk("in_ready_at_beat", {31'd0, bus_a.in_ready}, 32'd1);
      tick();
      last_acc       = cyc;
      bus_a.in_valid = 1'b0;
      bus_a.in_data  = 6'd0;
      bus_a.in_last  = 1'b0;
   endtask

   task automatic wait_a(input int exp_lat);
      n = 0;
      while (!bus_a.out_valid && n < 40) begin
         tick();
         n++;
      end
      chk("out_valid_rise", {31'd0, bus_a.out_valid}, 32'd1);
      chk("latency", cyc - last_acc, exp_lat);
   endtask

   task automatic release_a();
      bus_a.out_ready = 1'b1;
      tick();
      bus_a.out_ready = 1'b0;
      chk("rel_out_valid", {31'd0, bus_a.out_valid}, 32'd0);
      chk("rel_out_sum", {20'd0, bus_a.out_sum}, 32'd0);
      chk("rel_in_ready", {31'd0, bus_a.in_ready}, 32'd1);
      chk("rel_busy", {31'd0, bus_a.busy}, 32'd0);
   endtask

   initial begin
      rst_n           = 1'b0;
      bus_a.in_valid  = 1'b0;
      bus_a.in_data   = 6'd0;
      bus_a.in_last   = 1'b0;
      bus_a.out_ready = 1'b0;
      bus_b.in_valid  = 1'b0;
      bus_b.in_data   = 6'd0;
      bus_b.in_last   = 1'b0;
      bus_b.out_ready = 1'b0;

      // reset state
      tick();
      tick();
      chk("rst_in_ready_low", {31'd0, bus_a.in_ready}, 32'd0);
      chk("rst_out_valid", {31'd0, bus_a.out_valid}, 32'd0);
      chk("rst_out_sum", {20'd0, bus_a.out_sum}, 32'd0);
      chk("rst_out_count", {24'd0, bus_a.out_count}, 32'd0);
      chk("rst_busy", {31'd0, bus_a.busy}, 32'd0);
      rst_n = 1'b1;
      #1;
      chk("post_rst_in_ready", {31'd0, bus_a.in_ready}, 32'd1);

      // basic accumulate 63+63+63: two nonzero resolve steps
      send_a(6'd63, 1'b0);
      chk("accum_busy", {31'd0, bus_a.busy}, 32'd1);
      send_a(6'd63, 1'b0);
      send_a(6'd63, 1'b1);
      chk("resolve_in_ready", {31'd0, bus_a.in_ready}, 32'd0);
      chk("resolve_out_sum_zero", {20'd0, bus_a.out_sum}, 32'd0);
      wait_a(3);
      chk("basic_sum", {20'd0, bus_a.out_sum}, 32'd189);
      chk("basic_ovf", {31'd0, bus_a.out_ovf}, 32'd0);
      chk("basic_count", {24'd0, bus_a.out_count}, 32'd3);
      release_a();

      // single-beat group: exactly one resolve cycle
      send_a(6'd5, 1'b1);
      wait_a(1);
      chk("single_sum", {20'd0, bus_a.out_sum}, 32'd5);
      chk("single_count", {24'd0, bus_a.out_count}, 32'd1);
      release_a();

      // long carry chain 63+1: six nonzero resolve steps
      send_a(6'd63, 1'b0);
      send_a(6'd1, 1'b1);
      wait_a(7);
      chk("chain_sum", {20'd0, bus_a.out_sum}, 32'd64);
      chk("chain_ovf", {31'd0, bus_a.out_ovf}, 32'd0);
      chk("chain_count", {24'd0, bus_a.out_count}, 32'd2);
      release_a();

      // overflow on the 6-bit instance: 63+1 wraps to 0
      bus_b.in_valid = 1'b1;
      bus_b.in_data  = 6'd63;
      bus_b.in_last  = 1'b0;
      tick();
      bus_b.in_data  = 6'd1;
      bus_b.in_last  = 1'b1;
      tick();
      last_acc       = cyc;
      bus_b.in_valid = 1'b0;
      bus_b.in_last  = 1'b0;
      bus_b.in_data  = 6'd0;
      n = 0;
      while (!bus_b.out_valid && n < 40) begin
         tick();
         n++;
      end
      chk("ovf_out_valid", {31'd0, bus_b.out_valid}, 32'd1);
      chk("ovf_latency", cyc - last_acc, 32'd6);
      chk("ovf_sum", {26'd0, bus_b.out_sum}, 32'd0);
      chk("ovf_flag", {31'd0, bus_b.out_ovf}, 32'd1);
      chk("ovf_count", {24'd0, bus_b.out_count}, 32'd2);
      bus_b.out_ready = 1'b1;
      tick();
      bus_b.out_ready = 1'b0;
      chk("ovf_rel_valid", {31'd0, bus_b.out_valid}, 32'd0);
      chk("ovf_rel_flag", {31'd0, bus_b.out_ovf}, 32'd0);

      // backpressure: result held, inputs ignored
      send_a(6'd10, 1'b0);
      send_a(6'd20, 1'b1);
      wait_a(1);
      bus_a.in_valid = 1'b1;
      bus_a.in_data  = 6'd33;
      bus_a.in_last  = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("bp_out_valid", {31'd0, bus_a.out_valid}, 32'd1);
         chk("bp_out_sum", {20'd0, bus_a.out_sum}, 32'd30);
         chk("bp_out_count", {24'd0, bus_a.out_count}, 32'd2);
         chk("bp_in_ready", {31'd0, bus_a.in_ready}, 32'd0);
      end
      // transfer edge with in_valid still high: must not be accepted
      bus_a.out_ready = 1'b1;
      tick();
      bus_a.out_ready = 1'b0;
      bus_a.in_valid  = 1'b0;
      bus_a.in_last   = 1'b0;
      bus_a.in_data   = 6'd0;
      chk("bp_xfer_valid", {31'd0, bus_a.out_valid}, 32'd0);
      chk("bp_xfer_busy", {31'd0, bus_a.busy}, 32'd0);
      chk("bp_xfer_in_ready", {31'd0, bus_a.in_ready}, 32'd1);
      send_a(6'd2, 1'b0);
      send_a(6'd3, 1'b1);
      wait_a(2);
      chk("bp_next_sum", {20'd0, bus_a.out_sum}, 32'd5);
      chk("bp_next_count", {24'd0, bus_a.out_count}, 32'd2);
      chk("bp_next_ovf", {31'd0, bus_a.out_ovf}, 32'd0);
      release_a();

      // reset in the middle of a group
      send_a(6'd1, 1'b0);
      send_a(6'd2, 1'b0);
      rst_n = 1'b0;
      tick();
      chk("mid_rst_in_ready", {31'd0, bus_a.in_ready}, 32'd0);
      chk("mid_rst_busy", {31'd0, bus_a.busy}, 32'd0);
      chk("mid_rst_out_valid", {31'd0, bus_a.out_valid}, 32'd0);
      chk("mid_rst_out_count", {24'd0, bus_a.out_count}, 32'd0);
      rst_n = 1'b1;
      #1;
      chk("mid_rst_release_ready", {31'd0, bus_a.in_ready}, 32'd1);
      send_a(6'd7, 1'b0);
      send_a(6'd8, 1'b1);
      wait_a(1);
      chk("after_rst_sum", {20'd0, bus_a.out_sum}, 32'd15);
      chk("after_rst_count", {24'd0, bus_a.out_count}, 32'd2);
      release_a();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
